// File: rtl/framebuffer_pkg.sv
// Shared framebuffer definitions: bus widths, default geometry, scanout FSM states.
package framebuffer_pkg;

  localparam int unsigned FB_ADDR_W      = 17;
  localparam int unsigned FB_DATA_W      = 16;
  localparam int unsigned FB_WIDTH_DEF   = 320;
  localparam int unsigned FB_HEIGHT_DEF  = 240;
  localparam int unsigned FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } scanout_state_e;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous flush.
// DEPTH must be a power of two; pointers wrap naturally.
module scanout_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; flush discards everything including a same-cycle push.
  always_comb begin
    do_push  = push & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // The upstream credit scheme must never push into a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer scanout engine: raster-order reads from framebuffer port B into a pixel FIFO,
// presented as a valid/ready RGB565 stream with end-of-line / end-of-frame markers.
// Optional build macro SCANOUT_UNDERFLOW_COUNT_EN adds the saturating underflowCount output.
module framebuffer_scanout
  import framebuffer_pkg::*;
#(
  parameter int unsigned FB_WIDTH   = FB_WIDTH_DEF,
  parameter int unsigned FB_HEIGHT  = FB_HEIGHT_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 frameStart,
  output logic [FB_ADDR_W-1:0] fbAddress,
  output logic                 fbReadEnable,
  output logic                 fbWriteEnable,
  input  logic [FB_DATA_W-1:0] fbDataIn,
  output logic [FB_DATA_W-1:0] pixelData,
  output logic                 pixelValid,
  input  logic                 pixelReady,
  output logic                 pixelEndLine,
  output logic                 pixelEndFrame,
  output logic                 busy,
  output logic                 underflow
`ifdef SCANOUT_UNDERFLOW_COUNT_EN
 ,output logic [15:0]          underflowCount
`endif
);

  localparam int unsigned NUM_PIX = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned XW      = cnt_width(FB_WIDTH);
  localparam int unsigned YW      = cnt_width(FB_HEIGHT);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(NUM_PIX - 1);
  localparam logic [XW-1:0]        X_MAX     = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0]        Y_MAX     = YW'(FB_HEIGHT - 1);
  localparam logic [CW:0]          DEPTH_C   = (CW+1)'(FIFO_DEPTH);

  scanout_state_e       state_q, state_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic                 inflight_q, inflight_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;

  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic [FB_DATA_W-1:0] fifo_data;
  logic [CW:0]          occupancy;
  logic                 credit_ok;
  logic                 issue;
  logic                 pop;
  logic                 end_line;
  logic                 end_frame;

  scanout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FB_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetN),
    .flush     (frameStart),
    .push      (inflight_q),
    .push_data (fbDataIn),
    .pop       (pop),
    .pop_data  (fifo_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign fbAddress     = addr_q;
  assign fbReadEnable  = issue;
  assign fbWriteEnable = 1'b0;
  assign pixelData     = fifo_data;
  assign pixelValid    = ~fifo_empty;
  assign pixelEndLine  = end_line;
  assign pixelEndFrame = end_frame;
  assign busy          = (state_q != IDLE);
  assign underflow     = pixelReady & ~pixelValid & busy & ~frameStart;

  // Credit check, read issue, pop-side markers.
  // A frameStart cycle issues no read, so nothing from the aborted frame is left in flight.
  always_comb begin
    pop       = pixelValid & pixelReady;
    occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q);
    credit_ok = (occupancy < DEPTH_C);
    issue     = (state_q == FETCH) & credit_ok & ~frameStart;
    end_line  = (x_q == X_MAX);
    end_frame = end_line & (y_q == Y_MAX);
  end

  // FSM, read address and x/y counters; frameStart overrides everything, including the final accept.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    inflight_d = issue;
    x_d        = x_q;
    y_d        = y_q;
    if (frameStart) begin
      state_d = FETCH;
      addr_d  = '0;
      x_d     = '0;
      y_d     = '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (issue) begin
            if (addr_q == LAST_ADDR) state_d = DRAIN;
            else                     addr_d  = addr_q + FB_ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (pop && end_frame) state_d = IDLE;
        end
        default: state_d = state_q;
      endcase
      if (pop) begin
        if (end_line) begin
          x_d = '0;
          y_d = end_frame ? '0 : y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

`ifdef SCANOUT_UNDERFLOW_COUNT_EN
  logic [15:0] ucount_q, ucount_d;

  // Saturating underflow event count.
  always_comb begin
    ucount_d = ucount_q;
    if (underflow && (ucount_q != '1)) ucount_d = ucount_q + 16'd1;
  end

  // Underflow counter register, cleared only by reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) ucount_q <= '0;
    else         ucount_q <= ucount_d;
  end

  assign underflowCount = ucount_q;
`endif

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Self-checking bench for framebuffer_scanout on a reduced 12x10 frame.
// Framebuffer model: 1-cycle-latency memory returning address[15:0].
module tb_framebuffer_scanout;

  localparam int unsigned W     = 12;
  localparam int unsigned H     = 10;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NPIX  = W * H;

  logic        clk = 1'b0;
  logic        resetN;
  logic        frameStart;
  logic [16:0] fbAddress;
  logic        fbReadEnable;
  logic        fbWriteEnable;
  logic [15:0] fbDataIn;
  logic [15:0] pixelData;
  logic        pixelValid;
  logic        pixelReady;
  logic        pixelEndLine;
  logic        pixelEndFrame;
  logic        busy;
  logic        underflow;
`ifdef SCANOUT_UNDERFLOW_COUNT_EN
  logic [15:0] underflowCount;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_idx  = 0;
  int n_acc    = 0;
  int n_reads  = 0;
  int n_uf     = 0;

  framebuffer_scanout #(
    .FB_WIDTH   (W),
    .FB_HEIGHT  (H),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .frameStart    (frameStart),
    .fbAddress     (fbAddress),
    .fbReadEnable  (fbReadEnable),
    .fbWriteEnable (fbWriteEnable),
    .fbDataIn      (fbDataIn),
    .pixelData     (pixelData),
    .pixelValid    (pixelValid),
    .pixelReady    (pixelReady),
    .pixelEndLine  (pixelEndLine),
    .pixelEndFrame (pixelEndFrame),
    .busy          (busy),
    .underflow     (underflow)
`ifdef SCANOUT_UNDERFLOW_COUNT_EN
   ,.underflowCount (underflowCount)
`endif
  );

  always #5 clk = ~clk;

  // Framebuffer memory model: pixel value is the low 16 address bits, one cycle after the read.
  always @(posedge clk) begin
    if (fbReadEnable) fbDataIn <= fbAddress[15:0];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Sample at the falling edge; every accepted pixel is compared with the raster-order model.
  task automatic sample();
    @(negedge clk);
    if (fbReadEnable) n_reads++;
    if (underflow)    n_uf++;
    if (pixelValid && pixelReady) begin
      check_eq("pix_data", 32'(pixelData), 32'(exp_idx % 65536));
      check_eq("pix_eol", 32'(pixelEndLine), 32'((exp_idx % W) == W - 1));
      check_eq("pix_eof", 32'(pixelEndFrame), 32'(exp_idx == NPIX - 1));
      check_eq("fb_wen", 32'(fbWriteEnable), 32'd0);
      exp_idx++;
      n_acc++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic pulse_frame_start();
    frameStart = 1'b1;
    cycle();
    frameStart = 1'b0;
    exp_idx = 0;
    n_acc   = 0;
    n_reads = 0;
  endtask

  task automatic run_until(input int target, input int budget, input bit rnd);
    for (int k = 0; k < budget && n_acc < target; k++) begin
      pixelReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
    end
  endtask

  task automatic frame_done_checks(input string tag);
    check_eq({tag, "_acc"}, 32'(n_acc), 32'(NPIX));
    check_eq({tag, "_reads"}, 32'(n_reads), 32'(NPIX));
    pixelReady = 1'b1;
    sample();
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_valid_end"}, 32'(pixelValid), 32'd0);
    check_eq({tag, "_uf_idle"}, 32'(underflow), 32'd0);
    advance();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN     = 1'b0;
    frameStart = 1'b0;
    pixelReady = 1'b1;
    fbDataIn   = '0;
    repeat (2) advance();
    sample();
    check_eq("rst_addr", 32'(fbAddress), 32'd0);
    check_eq("rst_ren", 32'(fbReadEnable), 32'd0);
    check_eq("rst_valid", 32'(pixelValid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_uf", 32'(underflow), 32'd0);
    advance();
    resetN = 1'b1;
    n_uf = 0;

    // Ready asserted while idle must not flag underflow.
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("idle_uf", 32'(underflow), 32'd0);
      advance();
    end

    // Frame with constant ready: start-up timing, then full in-order stream.
    frameStart = 1'b1;
    sample();
    check_eq("fs_uf", 32'(underflow), 32'd0);
    check_eq("fs_ren", 32'(fbReadEnable), 32'd0);
    advance();
    frameStart = 1'b0;
    exp_idx = 0; n_acc = 0; n_reads = 0;
    sample();
    check_eq("t0_ren", 32'(fbReadEnable), 32'd1);
    check_eq("t0_addr", 32'(fbAddress), 32'd0);
    check_eq("t0_busy", 32'(busy), 32'd1);
    check_eq("t0_uf", 32'(underflow), 32'd1);
    advance();
    sample();
    check_eq("t1_addr", 32'(fbAddress), 32'd1);
    check_eq("t1_valid", 32'(pixelValid), 32'd0);
    check_eq("t1_uf", 32'(underflow), 32'd1);
    advance();
    sample();
    check_eq("t2_valid", 32'(pixelValid), 32'd1);
    check_eq("t2_uf", 32'(underflow), 32'd0);
    advance();
    run_until(NPIX, 1000, 1'b0);
    frame_done_checks("f1");
    check_eq("f1_uf_pulses", 32'(n_uf), 32'd2);
`ifdef SCANOUT_UNDERFLOW_COUNT_EN
    check_eq("f1_uf_count", 32'(underflowCount), 32'(n_uf));
`endif

    // Back-pressure: reads stop once the FIFO and in-flight credit are exhausted.
    pixelReady = 1'b0;
    pulse_frame_start();
    for (int i = 0; i < 50; i++) cycle();
    check_eq("bp_reads", 32'(n_reads), 32'(DEPTH));
    sample();
    check_eq("bp_ren", 32'(fbReadEnable), 32'd0);
    check_eq("bp_valid", 32'(pixelValid), 32'd1);
    advance();
    pixelReady = 1'b1;
    cycle();
    pixelReady = 1'b0;
    sample();
    check_eq("bp_credit_ret", 32'(fbReadEnable), 32'd1);
    advance();
    run_until(NPIX, 4000, 1'b1);
    frame_done_checks("f2");

    // Random ready over a full frame.
    pulse_frame_start();
    run_until(NPIX, 4000, 1'b1);
    frame_done_checks("f3");

    // Restart mid-frame: the stream must begin again at pixel 0 with no stale data.
    pulse_frame_start();
    run_until(100, 4000, 1'b1);
    check_eq("ab_pre_acc", 32'(n_acc), 32'd100);
    pixelReady = 1'b0;
    cycle();
    pixelReady = 1'b1;
    pulse_frame_start();
    sample();
    check_eq("ab_valid_flushed", 32'(pixelValid), 32'd0);
    check_eq("ab_restart_addr", 32'(fbAddress), 32'd0);
    advance();
    run_until(NPIX, 4000, 1'b1);
    frame_done_checks("f4");

    // Asynchronous reset mid-frame, applied between clock edges.
    pulse_frame_start();
    pixelReady = 1'b1;
    run_until(20, 200, 1'b0);
    #2;
    resetN = 1'b0;
    #1;
    check_eq("ar_addr", 32'(fbAddress), 32'd0);
    check_eq("ar_ren", 32'(fbReadEnable), 32'd0);
    check_eq("ar_valid", 32'(pixelValid), 32'd0);
    check_eq("ar_busy", 32'(busy), 32'd0);
    check_eq("ar_uf", 32'(underflow), 32'd0);
    advance();
    resetN = 1'b1;
    n_reads = 0; n_acc = 0; n_uf = 0;
    for (int i = 0; i < 10; i++) cycle();
    check_eq("ar_no_reads", 32'(n_reads), 32'd0);
    check_eq("ar_no_pixels", 32'(n_acc), 32'd0);
    check_eq("ar_no_uf", 32'(n_uf), 32'd0);

    // Normal frame after reset recovery.
    pulse_frame_start();
    run_until(NPIX, 4000, 1'b1);
    frame_done_checks("f5");
`ifdef SCANOUT_UNDERFLOW_COUNT_EN
    check_eq("f5_uf_count", 32'(underflowCount), 32'(n_uf));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
